data_memory: RTL and testbench
==============================

# data_memory

Word-addressed, single-port data memory for the MIPS CPU datapath, serving the load/store stage. It holds 2^ADDR_WIDTH words of DATA_WIDTH bits. Writes are synchronous on the rising clock edge when write-enabled. Reads are combinational, so a load completes in the same cycle. An asynchronous active-low reset clears the entire array to zero.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 10, word-address width; depth = 2^ADDR_WIDTH (1024 words)

Ports:
- clk  input  1  system clock; all writes on its rising edge
- rst_n  input  1  reset, asynchronous, active-low; one clock domain only
- address  input  ADDR_WIDTH  word address; no byte offset, no alignment bits
- we  input  1  write enable, active-high
- dataIn  input  DATA_WIDTH  write data
- dataOut  output  DATA_WIDTH  read data = contents of the word at address

## Operation
- Storage is an array of 2^ADDR_WIDTH words of DATA_WIDTH bits, implemented as registers so that reset can clear it.
- Reset:
  - When rst_n = 0, every word is cleared to 0 immediately, independent of clk.
  - The array holds 0 while rst_n stays low; writes are ignored.
  - dataOut = 0 for any address while rst_n is low.
- Write:
  - On a rising clk edge with rst_n = 1 and we = 1, mem[address] <= dataIn.
  - Only the addressed word changes.
- Read:
  - dataOut = mem[address] continuously (combinational).
  - Independent of we.
  - A change on address is reflected on dataOut with no clock.
- Read-during-write:
  - Before the edge, dataOut shows the old contents.
  - After the edge, dataOut shows the newly written value (write-first as seen after the edge).
- Address range:
  - Every value of address is valid. There is no out-of-range condition and no wrap logic.
  - 0 and 2^ADDR_WIDTH-1 behave like any other word.
- Unwritten words read 0 after reset. With no reset applied since power-up, contents are undefined (X in simulation).
- No byte or halfword enables; every write is a full-word write.

## Timing
- Write latency: 1 clock. Data is present at the rising edge and readable right after that edge.
- Read latency: 0 cycles (combinational from address and array contents).
- Reset:
  - Asserts asynchronously.
  - Deassertion is taken synchronously by the write path: the first write can occur on the first rising edge after rst_n is sampled high.
  - rst_n must meet recovery time relative to clk.
- Reset output value: dataOut = 0.
- Simultaneous rst_n low and we = 1 at an edge: reset wins and the word stays 0.
- Reset mid-operation: all previously written data is lost. Reads return 0 after release until words are rewritten.
- Back-to-back writes to the same address on consecutive edges: the last write wins.
- Back-to-back writes to different addresses: each takes effect on its own edge.

## Test plan
- Reset scan:
  - Stimulus: pulse rst_n low, release, we = 0, sweep address 0..1023 one per 20 ns clock (clk period 20 ns).
  - Required response: dataOut = 0x00000000 at every address.
- Write/readback:
  - Stimulus: write 0xDEADBEEF to address 5 and 0x12345678 to address 6, then read both.
  - Required response: exactly those values; address 4 and address 7 still read 0.
- Write-enable gating:
  - Stimulus: we = 0 with dataIn = 0xFFFFFFFF at address 5 across 3 edges.
  - Required response: address 5 still reads 0xDEADBEEF.
- Boundaries:
  - Stimulus: write 0xA5A5A5A5 to address 0 and 0x5A5A5A5A to address 1023.
  - Required response: both read back correctly; address 1 and address 1022 are unaffected.
- Read-during-write:
  - Stimulus: address 10 holds 0x1; drive we = 1 and dataIn = 0x2.
  - Required response: dataOut = 0x1 before the edge and 0x2 immediately after it.
- Reset mid-run:
  - Stimulus: after the writes above, pull rst_n low between edges while we = 1.
  - Required response: dataOut drops to 0 without waiting for clk; addresses 0, 5, 1023 read 0 after release; no write occurs while rst_n is low.

Source files
------------

// File: rtl/data_memory.sv
// data_memory: word-addressed single-port data memory for the load/store
// stage. Synchronous full-word writes, combinational reads, and an
// asynchronous active-low reset that clears every word to zero.
module data_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic [DATA_WIDTH-1:0] dataOut
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Storage is held in flops rather than a RAM macro so reset can clear it.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Combinational read of the addressed word before output gating.
    logic [DATA_WIDTH-1:0] w_readWord;

    // Reset clears the whole array; otherwise a write-enabled edge updates one word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[address] <= dataIn;
        end
    end

    // Read path follows the address with no clock; forced to zero while in reset.
    always_comb begin
        w_readWord = r_mem[address];
        dataOut    = rst_n ? w_readWord : '0;
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed vector table, hand-written
// multi-cycle corner sequences, and randomized traffic against an array model.
module tb_data_memory;

    logic        clk;
    logic        rst_n;
    logic [9:0]  address;
    logic        we;
    logic [31:0] dataIn;
    logic [31:0] dataOut;

    int checks;
    int errors;

    logic [31:0] model [1024];

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .address (address),
        .we      (we),
        .dataIn  (dataIn),
        .dataOut (dataOut)
    );

    // 20 ns clock.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Drive inputs mid-cycle, just after the falling edge.
    task automatic applyStimulus(input logic w, input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        we      = w;
        address = a;
        dataIn  = d;
        #1;
    endtask

    // Let the rising edge happen, then update the model with what the memory should store.
    task automatic clockEdge();
        @(posedge clk);
        if (we && rst_n) model[address] = dataIn;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] exp);
        checks++;
        if (dataOut !== exp) begin
            errors++;
            $display("[TB] FAIL %s: addr=%0d got %h expected %h", name, address, dataOut, exp);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 1024; i++) model[i] = '0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b1;
        we      = 1'b0;
        address = '0;
        dataIn  = '0;

        // Power-up reset with a genuine falling edge on rst_n.
        #5 rst_n = 1'b0;
        clearModel();
        #1 checkOutput("reset_out_a0", 32'h0);
        address = 10'd517;
        #1 checkOutput("reset_out_a517", 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset scan: every word reads zero, one address per clock.
        for (int a = 0; a < 1024; a++) begin
            applyStimulus(1'b0, a[9:0], $urandom);
            checkOutput("reset_scan", 32'h0);
        end

        // Directed vector table: apply, clock, then check the addressed word.
        vecs.push_back('{1'b1, 10'd5,    32'hDEADBEEF, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 10'd6,    32'h12345678, 32'h12345678});
        vecs.push_back('{1'b0, 10'd5,    32'h00000000, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 10'd6,    32'h00000000, 32'h12345678});
        vecs.push_back('{1'b0, 10'd4,    32'h00000000, 32'h00000000});
        vecs.push_back('{1'b0, 10'd7,    32'h00000000, 32'h00000000});
        vecs.push_back('{1'b0, 10'd5,    32'hFFFFFFFF, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 10'd5,    32'hFFFFFFFF, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 10'd5,    32'hFFFFFFFF, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 10'd0,    32'hA5A5A5A5, 32'hA5A5A5A5});
        vecs.push_back('{1'b1, 10'd1023, 32'h5A5A5A5A, 32'h5A5A5A5A});
        vecs.push_back('{1'b0, 10'd1,    32'h00000000, 32'h00000000});
        vecs.push_back('{1'b0, 10'd1022, 32'h00000000, 32'h00000000});
        vecs.push_back('{1'b0, 10'd0,    32'h00000000, 32'hA5A5A5A5});
        vecs.push_back('{1'b0, 10'd1023, 32'h00000000, 32'h5A5A5A5A});
        vecs.push_back('{1'b1, 10'd10,   32'h00000001, 32'h00000001});
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].din);
            clockEdge();
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Read-during-write: old value before the edge, new value right after.
        applyStimulus(1'b1, 10'd10, 32'h00000002);
        checkOutput("rdw_before", 32'h00000001);
        clockEdge();
        checkOutput("rdw_after", 32'h00000002);

        // Address change is reflected without any clock edge.
        we = 1'b0;
        address = 10'd6;
        #1 checkOutput("comb_read_a6", 32'h12345678);
        address = 10'd1023;
        #1 checkOutput("comb_read_a1023", 32'h5A5A5A5A);

        // Back-to-back writes to one address: the last one wins.
        applyStimulus(1'b1, 10'd20, 32'h00000011);
        clockEdge();
        applyStimulus(1'b1, 10'd20, 32'h00000022);
        clockEdge();
        applyStimulus(1'b0, 10'd20, 32'h0);
        checkOutput("b2b_same", 32'h00000022);

        // Randomized traffic against the array model.
        for (int n = 0; n < 400; n++) begin
            logic [9:0]  ra;
            logic [31:0] rd;
            logic        rw;
            ra = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(0, 1023));
            rd = $urandom;
            rw = ($urandom_range(0, 2) != 0);
            applyStimulus(rw, ra, rd);
            checkOutput("rand_pre", model[ra]);
            clockEdge();
            checkOutput("rand_post", model[ra]);
            address = 10'($urandom_range(0, 1023));
            #1 checkOutput("rand_comb", model[address]);
        end

        // Reset mid-run: drop rst_n between edges while a write is pending.
        applyStimulus(1'b1, 10'd5, 32'h77777777);
        clockEdge();
        checkOutput("pre_reset_a5", 32'h77777777);
        applyStimulus(1'b1, 10'd5, 32'hCAFEF00D);
        #3 rst_n = 1'b0;
        clearModel();
        #1 checkOutput("reset_async_drop", 32'h0);
        clockEdge();
        checkOutput("reset_blocks_write", 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        we    = 1'b0;
        applyStimulus(1'b0, 10'd0, 32'h0);
        checkOutput("post_reset_a0", 32'h0);
        applyStimulus(1'b0, 10'd5, 32'h0);
        checkOutput("post_reset_a5", 32'h0);
        applyStimulus(1'b0, 10'd1023, 32'h0);
        checkOutput("post_reset_a1023", 32'h0);

        // First write after release takes effect normally.
        applyStimulus(1'b1, 10'd5, 32'h0BADF00D);
        clockEdge();
        checkOutput("post_reset_write", 32'h0BADF00D);
        applyStimulus(1'b0, 10'd6, 32'h0);
        checkOutput("post_reset_a6", 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
